sram2rw_arbiter: RTL

- Shares one 128x8 two-port RW SRAM macro (SRAM2RW128x8-style pin set) among NREQ requesters, each using a valid/ready request interface.
- Each cycle, a round-robin scheduler grants up to two requests: one to port 1 and one to port 2.
- It drives the macro's active-low chip-select/write/output-enable pins and returns read data tagged to the originating requester one cycle later.
- Sits between cache/scratchpad clients and the macro. Both macro clock pins (CE1/CE2) are tied to clk outside this block.

---
 rtl/sram2rw_pkg.sv | 42 ++++
 rtl/rr_pick2.sv | 67 ++++++
 rtl/sram2rw_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sram2rw_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram2rw_pkg - macro geometry, per-port command type and request encoder
// Rev 1.0
// ---------------------------------------------------------------------------
package sram2rw_pkg;

  localparam int SRAM_AW    = 7;
  localparam int SRAM_DW    = 8;
  localparam int SRAM_DEPTH = 1 << SRAM_AW;

  typedef struct packed {
    logic               csb;
    logic               web;
    logic               oeb;
    logic [SRAM_AW-1:0] a;
    logic [SRAM_DW-1:0] i;
  } port_cmd_t;

  localparam port_cmd_t PORT_IDLE = '{csb: 1'b1, web: 1'b1, oeb: 1'b1, a: '0, i: '0};

  // web and oeb are always complementary on a selected port, so both can never be low together
  function automatic port_cmd_t encode_cmd(
    input logic               grant,
    input logic               we,
    input logic [SRAM_AW-1:0] addr,
    input logic [SRAM_DW-1:0] wdata
  );
    port_cmd_t cmd;
    cmd = PORT_IDLE;
    if (grant) begin
      cmd.csb = 1'b0;
      cmd.a   = addr;
      cmd.web = ~we;
      cmd.oeb = we;
      cmd.i   = we ? wdata : '0;
    end
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_pick2 - combinational two-winner round-robin picker with address conflict check
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_pick2 #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int AW   = 7
) (
  input  logic [NREQ-1:0]    valid,
  input  logic [IDW-1:0]     ptr,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ-1:0]    we,
  output logic               g1_v,
  output logic [IDW-1:0]     g1_idx,
  output logic               g2_v,
  output logic [IDW-1:0]     g2_idx
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [AW-1:0]  addr_arr [NREQ];
  logic           cand_v;
  logic [IDW-1:0] cand_idx;
  logic           conflict;

  generate
    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
      assign addr_arr[r] = addr[r*AW +: AW];
    end
  endgenerate

  always_comb begin
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    g1_v     = 1'b0;
    g1_idx   = '0;
    cand_v   = 1'b0;
    cand_idx = '0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NREQ_W) begin
        sum = sum - NREQ_W;
      end
      idx = sum[IDW-1:0];
      if (valid[idx]) begin
        if (!g1_v) begin
          g1_v   = 1'b1;
          g1_idx = idx;
        end else if (!cand_v) begin
          cand_v   = 1'b1;
          cand_idx = idx;
        end
      end
    end
  end

  // Same-address pair is only safe when both sides read; otherwise port 2 backs off
  assign conflict = (addr_arr[g1_idx] == addr_arr[cand_idx]) && (we[g1_idx] || we[cand_idx]);
  assign g2_v     = cand_v && !conflict;
  assign g2_idx   = cand_idx;

endmodule
`default_nettype wire

// File: rtl/sram2rw_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sram2rw_arbiter - shares a 128x8 two-port RW SRAM among NREQ valid/ready clients
// Rev 1.0
// ---------------------------------------------------------------------------
module sram2rw_arbiter
  import sram2rw_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = SRAM_AW,
  parameter int DW   = SRAM_DW,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [NREQ*DW-1:0] rsp_rdata,
  output logic [AW-1:0]     sram_a1,
  output logic [AW-1:0]     sram_a2,
  output logic              sram_csb1,
  output logic              sram_csb2,
  output logic              sram_web1,
  output logic              sram_web2,
  output logic              sram_oeb1,
  output logic              sram_oeb2,
  output logic [DW-1:0]     sram_i1,
  output logic [DW-1:0]     sram_i2,
  input  logic [DW-1:0]     sram_o1,
  input  logic [DW-1:0]     sram_o2
);

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_nxt;
  logic           pend_v1;
  logic           pend_v2;
  logic [IDW-1:0] pend_id1;
  logic [IDW-1:0] pend_id2;

  logic           pick_g1_v;
  logic           pick_g2_v;
  logic           g1_v;
  logic           g2_v;
  logic [IDW-1:0] g1_idx;
  logic [IDW-1:0] g2_idx;
  logic [IDW-1:0] last_idx;

  logic [AW-1:0]  addr_arr  [NREQ];
  logic [DW-1:0]  wdata_arr [NREQ];
  port_cmd_t      cmd1;
  port_cmd_t      cmd2;

  generate
    for (genvar r = 0; r < NREQ; r++) begin : g_unpack
      assign addr_arr[r]  = req_addr[r*AW +: AW];
      assign wdata_arr[r] = req_wdata[r*DW +: DW];
    end
  endgenerate

  rr_pick2 #(
    .NREQ (NREQ),
    .IDW  (IDW),
    .AW   (AW)
  ) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .addr   (req_addr),
    .we     (req_we),
    .g1_v   (pick_g1_v),
    .g1_idx (g1_idx),
    .g2_v   (pick_g2_v),
    .g2_idx (g2_idx)
  );

  // Reset holds every grant off so the macro pins and ready stay idle while rst_n is low
  assign g1_v = rst_n && pick_g1_v;
  assign g2_v = rst_n && pick_g2_v;

  always_comb begin
    req_ready = '0;
    if (g1_v) begin
      req_ready[g1_idx] = 1'b1;
    end
    if (g2_v) begin
      req_ready[g2_idx] = 1'b1;
    end
  end

  always_comb begin
    cmd1 = encode_cmd(g1_v, req_we[g1_idx], addr_arr[g1_idx], wdata_arr[g1_idx]);
    cmd2 = encode_cmd(g2_v, req_we[g2_idx], addr_arr[g2_idx], wdata_arr[g2_idx]);
  end

  assign sram_csb1 = cmd1.csb;
  assign sram_web1 = cmd1.web;
  assign sram_oeb1 = cmd1.oeb;
  assign sram_a1   = cmd1.a;
  assign sram_i1   = cmd1.i;
  assign sram_csb2 = cmd2.csb;
  assign sram_web2 = cmd2.web;
  assign sram_oeb2 = cmd2.oeb;
  assign sram_a2   = cmd2.a;
  assign sram_i2   = cmd2.i;

  // Pointer resumes just past the most recent winner in scan order
  always_comb begin
    last_idx = g2_v ? g2_idx : g1_idx;
    if (last_idx == IDW'(NREQ - 1)) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      pend_v1  <= 1'b0;
      pend_v2  <= 1'b0;
      pend_id1 <= '0;
      pend_id2 <= '0;
    end else begin
      if (g1_v) begin
        rr_ptr <= ptr_nxt;
      end
      pend_v1  <= g1_v && !req_we[g1_idx];
      pend_id1 <= g1_idx;
      pend_v2  <= g2_v && !req_we[g2_idx];
      pend_id2 <= g2_idx;
    end
  end

  // One requester holds at most one grant per cycle, so hit1 and hit2 never coincide
  generate
    for (genvar r = 0; r < NREQ; r++) begin : g_rsp
      logic hit1;
      logic hit2;
      assign hit1 = rst_n && pend_v1 && (pend_id1 == IDW'(r));
      assign hit2 = rst_n && pend_v2 && (pend_id2 == IDW'(r));
      assign rsp_valid[r]          = hit1 || hit2;
      assign rsp_rdata[r*DW +: DW] = hit1 ? sram_o1 : (hit2 ? sram_o2 : '0);
    end
  endgenerate

endmodule
`default_nettype wire
